// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the decode/issue pipeline.
// Holds the operand-select (HSEL) codes, the NOP EX opcode, the
// hard-wired zero register and the default datapath widths.
// Optional feature macro used by the importers: ID_ISSUE_BYPASS_EN.
package pipeline_pkg;

    // Default widths used as parameter defaults throughout the stage.
    localparam int WORD_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int EXOP_W_DEF     = 8;
    localparam int FWD_STAGES_DEF = 2;
    localparam int CNT_W_DEF      = 16;

    // Operand source select; 2'b11 is reserved and behaves like ZERO.
    typedef enum logic [1:0] {
        HSEL_ZERO = 2'b00,
        HSEL_REG  = 2'b01,
        HSEL_IMM  = 2'b10
    } hsel_e;

    // EX opcode carried by a bubble.
    localparam int EXOP_NOP = 0;

    // Architectural register that always reads as zero.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/operand_select.sv
// operand_select: resolves one source operand of the issue stage.
// Chooses between zero, the immediate, the register file value and the
// forwarding buses, and flags a RAW hazard when the operand cannot be
// resolved this cycle.
// ID_ISSUE_BYPASS_EN defined  : forwarding from the youngest matching stage.
// ID_ISSUE_BYPASS_EN undefined: no forwarding; any pending writer stalls.
module operand_select
    import pipeline_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int FWD_STAGES = FWD_STAGES_DEF
) (
    input  logic [1:0]                       i_sel,
    input  logic [REG_ADDR_W-1:0]            i_addr,
    input  logic [WORD_W-1:0]                i_imm,
    input  logic [WORD_W-1:0]                i_regValue,
    input  logic [FWD_STAGES*REG_ADDR_W-1:0] i_stageDest,
    input  logic [FWD_STAGES-1:0]            i_stageWe,
    input  logic [FWD_STAGES-1:0]            i_stageResultValid,
    input  logic [FWD_STAGES*WORD_W-1:0]     i_stageResult,
    output logic [WORD_W-1:0]                o_value,
    output logic                             o_hazard
);

    logic w_found;

`ifndef ID_ISSUE_BYPASS_EN
    // Result buses are not consulted without forwarding.
    logic w_unused;
    assign w_unused = ^{i_stageResultValid, i_stageResult};
`endif

    // Operand value and hazard flag from select, address and stage buses.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the case/loop can leave it unassigned (no latch).
        o_value  = '0;
        o_hazard = 1'b0;
        w_found  = 1'b0;
        case (hsel_e'(i_sel))
            HSEL_IMM: o_value = i_imm;
            HSEL_REG: begin
                if (i_addr != REG_ADDR_W'(REG_ZERO)) begin
                    o_value = i_regValue;
`ifdef ID_ISSUE_BYPASS_EN
                    // Lowest index is the youngest writer, so it wins.
                    for (int k = 0; k < FWD_STAGES; k++) begin
                        if (!w_found && i_stageWe[k] &&
                            (i_stageDest[k*REG_ADDR_W +: REG_ADDR_W] == i_addr)) begin
                            w_found = 1'b1;
                            if (i_stageResultValid[k]) begin
                                o_value = i_stageResult[k*WORD_W +: WORD_W];
                            end else begin
                                o_hazard = 1'b1;
                            end
                        end
                    end
`else
                    // Without bypass any in-flight writer must retire first.
                    for (int k = 0; k < FWD_STAGES; k++) begin
                        if (i_stageWe[k] &&
                            (i_stageDest[k*REG_ADDR_W +: REG_ADDR_W] == i_addr)) begin
                            w_found  = 1'b1;
                            o_hazard = 1'b1;
                        end
                    end
`endif
                end
            end
            default: o_value = '0;
        endcase
    end

endmodule

// File: rtl/id_issue.sv
// id_issue: operand-fetch and issue stage between decode and EX.
// Resolves both operands (two operand_select instances), stalls on
// unresolved RAW hazards, and registers the issued instruction into an
// ID/EX register with valid/ready handshake, flush and a saturating
// stall counter.
// ID_ISSUE_BYPASS_EN selects forwarding (defined) or stall-only (undefined).
module id_issue
    import pipeline_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int EXOP_W     = EXOP_W_DEF,
    parameter int FWD_STAGES = FWD_STAGES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [EXOP_W-1:0]                i_exop,
    input  logic [1:0]                       i_leftSel,
    input  logic [1:0]                       i_rightSel,
    input  logic [REG_ADDR_W-1:0]            i_addrLeft,
    input  logic [REG_ADDR_W-1:0]            i_addrRight,
    input  logic [WORD_W-1:0]                i_imm,
    input  logic [WORD_W-1:0]                i_offset,
    input  logic [REG_ADDR_W-1:0]            i_dest,
    output logic [REG_ADDR_W-1:0]            o_readAddrLeft,
    output logic [REG_ADDR_W-1:0]            o_readAddrRight,
    input  logic [WORD_W-1:0]                i_readValueLeft,
    input  logic [WORD_W-1:0]                i_readValueRight,
    input  logic [FWD_STAGES*REG_ADDR_W-1:0] i_stageDest,
    input  logic [FWD_STAGES-1:0]            i_stageWe,
    input  logic [FWD_STAGES-1:0]            i_stageResultValid,
    input  logic [FWD_STAGES*WORD_W-1:0]     i_stageResult,
    input  logic                             i_flush,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [EXOP_W-1:0]                o_exop,
    output logic [WORD_W-1:0]                o_srcLeft,
    output logic [WORD_W-1:0]                o_srcRight,
    output logic [WORD_W-1:0]                o_offset,
    output logic [REG_ADDR_W-1:0]            o_dest,
    output logic [CNT_W-1:0]                 o_stallCount
);

    logic [WORD_W-1:0]     w_valueLeft;
    logic [WORD_W-1:0]     w_valueRight;
    logic                  w_hazardLeft;
    logic                  w_hazardRight;
    logic                  w_stall;
    logic                  w_advance;
    logic                  w_accept;

    logic                  r_valid;
    logic [EXOP_W-1:0]     r_exop;
    logic [WORD_W-1:0]     r_srcLeft;
    logic [WORD_W-1:0]     r_srcRight;
    logic [WORD_W-1:0]     r_offset;
    logic [REG_ADDR_W-1:0] r_dest;
    logic [CNT_W-1:0]      r_stallCount;

    // Register file read ports only see an address for REG operands.
    assign o_readAddrLeft  = (hsel_e'(i_leftSel)  == HSEL_REG) ? i_addrLeft  : '0;
    assign o_readAddrRight = (hsel_e'(i_rightSel) == HSEL_REG) ? i_addrRight : '0;

    operand_select #(
        .WORD_W     (WORD_W),
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_STAGES (FWD_STAGES)
    ) u_sel_left (
        .i_sel              (i_leftSel),
        .i_addr             (i_addrLeft),
        .i_imm              (i_imm),
        .i_regValue         (i_readValueLeft),
        .i_stageDest        (i_stageDest),
        .i_stageWe          (i_stageWe),
        .i_stageResultValid (i_stageResultValid),
        .i_stageResult      (i_stageResult),
        .o_value            (w_valueLeft),
        .o_hazard           (w_hazardLeft)
    );

    operand_select #(
        .WORD_W     (WORD_W),
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_STAGES (FWD_STAGES)
    ) u_sel_right (
        .i_sel              (i_rightSel),
        .i_addr             (i_addrRight),
        .i_imm              (i_imm),
        .i_regValue         (i_readValueRight),
        .i_stageDest        (i_stageDest),
        .i_stageWe          (i_stageWe),
        .i_stageResultValid (i_stageResultValid),
        .i_stageResult      (i_stageResult),
        .o_value            (w_valueRight),
        .o_hazard           (w_hazardRight)
    );

    // A hazard only matters when there is an instruction to issue.
    assign w_stall   = i_valid && (w_hazardLeft || w_hazardRight);
    // The ID/EX register may take new contents when empty or draining.
    assign w_advance = !r_valid || i_ready;
    assign o_ready   = !w_stall && w_advance && !rst;
    assign w_accept  = i_valid && o_ready;

    // ID/EX register: flush beats accept/bubble, which beat hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_exop     <= EXOP_W'(EXOP_NOP);
            r_srcLeft  <= '0;
            r_srcRight <= '0;
            r_offset   <= '0;
            r_dest     <= '0;
        end else if (i_flush) begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, independent of statement order.
            r_valid <= 1'b0;
            r_exop  <= EXOP_W'(EXOP_NOP);
            r_dest  <= '0;
        end else if (w_advance) begin
            if (w_accept) begin
                r_valid    <= 1'b1;
                r_exop     <= i_exop;
                r_srcLeft  <= w_valueLeft;
                r_srcRight <= w_valueRight;
                r_offset   <= i_offset;
                r_dest     <= i_dest;
            end else begin
                r_valid <= 1'b0;
                r_exop  <= EXOP_W'(EXOP_NOP);
                r_dest  <= '0;
            end
        end
    end

    // Saturating count of cycles lost to hazard stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCount <= '0;
        end else if (w_stall && (r_stallCount != '1)) begin
            r_stallCount <= r_stallCount + CNT_W'(1);
        end
    end

    assign o_valid      = r_valid;
    assign o_exop       = r_exop;
    assign o_srcLeft    = r_srcLeft;
    assign o_srcRight   = r_srcRight;
    assign o_offset     = r_offset;
    assign o_dest       = r_dest;
    assign o_stallCount = r_stallCount;

endmodule

// File: tb/tb_id_issue.sv
// tb_id_issue: directed self-checking bench for id_issue.
// Expectations follow ID_ISSUE_BYPASS_EN (forwarding vs stall-only).
module tb_id_issue;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int EXOP_W     = 8;
    localparam int FWD_STAGES = 2;
    localparam int CNT_W      = 4;

    logic                             clk;
    logic                             rst;
    logic                             i_valid;
    logic                             o_ready;
    logic [EXOP_W-1:0]                i_exop;
    logic [1:0]                       i_leftSel;
    logic [1:0]                       i_rightSel;
    logic [REG_ADDR_W-1:0]            i_addrLeft;
    logic [REG_ADDR_W-1:0]            i_addrRight;
    logic [WORD_W-1:0]                i_imm;
    logic [WORD_W-1:0]                i_offset;
    logic [REG_ADDR_W-1:0]            i_dest;
    logic [REG_ADDR_W-1:0]            o_readAddrLeft;
    logic [REG_ADDR_W-1:0]            o_readAddrRight;
    logic [WORD_W-1:0]                i_readValueLeft;
    logic [WORD_W-1:0]                i_readValueRight;
    logic [FWD_STAGES*REG_ADDR_W-1:0] i_stageDest;
    logic [FWD_STAGES-1:0]            i_stageWe;
    logic [FWD_STAGES-1:0]            i_stageResultValid;
    logic [FWD_STAGES*WORD_W-1:0]     i_stageResult;
    logic                             i_flush;
    logic                             o_valid;
    logic                             i_ready;
    logic [EXOP_W-1:0]                o_exop;
    logic [WORD_W-1:0]                o_srcLeft;
    logic [WORD_W-1:0]                o_srcRight;
    logic [WORD_W-1:0]                o_offset;
    logic [REG_ADDR_W-1:0]            o_dest;
    logic [CNT_W-1:0]                 o_stallCount;

    int n_checks = 0;
    int n_fail   = 0;

    id_issue #(
        .WORD_W     (WORD_W),
        .REG_ADDR_W (REG_ADDR_W),
        .EXOP_W     (EXOP_W),
        .FWD_STAGES (FWD_STAGES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_exop             (i_exop),
        .i_leftSel          (i_leftSel),
        .i_rightSel         (i_rightSel),
        .i_addrLeft         (i_addrLeft),
        .i_addrRight        (i_addrRight),
        .i_imm              (i_imm),
        .i_offset           (i_offset),
        .i_dest             (i_dest),
        .o_readAddrLeft     (o_readAddrLeft),
        .o_readAddrRight    (o_readAddrRight),
        .i_readValueLeft    (i_readValueLeft),
        .i_readValueRight   (i_readValueRight),
        .i_stageDest        (i_stageDest),
        .i_stageWe          (i_stageWe),
        .i_stageResultValid (i_stageResultValid),
        .i_stageResult      (i_stageResult),
        .i_flush            (i_flush),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_exop             (o_exop),
        .o_srcLeft          (o_srcLeft),
        .o_srcRight         (o_srcRight),
        .o_offset           (o_offset),
        .o_dest             (o_dest),
        .o_stallCount       (o_stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_valid            = 1'b0;
        i_exop             = '0;
        i_leftSel          = 2'b00;
        i_rightSel         = 2'b00;
        i_addrLeft         = '0;
        i_addrRight        = '0;
        i_imm              = '0;
        i_offset           = '0;
        i_dest             = '0;
        i_readValueLeft    = '0;
        i_readValueRight   = '0;
        i_stageDest        = '0;
        i_stageWe          = '0;
        i_stageResultValid = '0;
        i_stageResult      = '0;
        i_flush            = 1'b0;
        i_ready            = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #3;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_exop", 32'(o_exop), 32'd0);
        check("rst_dest", 32'(o_dest), 32'd0);
        check("rst_cnt", 32'(o_stallCount), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        cycle();
        cycle();
        rst = 1'b0;

        // ORI-style: left REG r3 (0x10), right IMM 0xFF.
        i_valid         = 1'b1;
        i_exop          = 8'h21;
        i_leftSel       = 2'b01;
        i_addrLeft      = 5'd3;
        i_rightSel      = 2'b10;
        i_addrRight     = 5'd9;
        i_imm           = 32'hFF;
        i_offset        = 32'h100;
        i_dest          = 5'd4;
        i_readValueLeft = 32'h10;
        #1;
        check("ori_raddrL", 32'(o_readAddrLeft), 32'd3);
        check("ori_raddrR", 32'(o_readAddrRight), 32'd0);
        check("ori_ready", 32'(o_ready), 32'd1);
        cycle();
        check("ori_valid", 32'(o_valid), 32'd1);
        check("ori_srcL", o_srcLeft, 32'h10);
        check("ori_srcR", o_srcRight, 32'hFF);
        check("ori_exop", 32'(o_exop), 32'h21);
        check("ori_dest", 32'(o_dest), 32'd4);
        check("ori_offset", o_offset, 32'h100);
        i_valid = 1'b0;
        cycle();
        check("bubble_valid", 32'(o_valid), 32'd0);
        check("bubble_exop", 32'(o_exop), 32'd0);
        check("bubble_dest", 32'(o_dest), 32'd0);

        // Forward priority: r5 written by stage0 (0xA) and stage1 (0xB).
        i_valid            = 1'b1;
        i_exop             = 8'h05;
        i_rightSel         = 2'b00;
        i_addrLeft         = 5'd5;
        i_readValueLeft    = 32'h55;
        i_stageDest        = {5'd5, 5'd5};
        i_stageWe          = 2'b11;
        i_stageResultValid = 2'b11;
        i_stageResult      = {32'hB, 32'hA};
        #1;
`ifdef ID_ISSUE_BYPASS_EN
        check("fwd0_ready", 32'(o_ready), 32'd1);
        cycle();
        check("fwd0_srcL", o_srcLeft, 32'hA);
        i_stageWe = 2'b10;
        #1;
        check("fwd1_ready", 32'(o_ready), 32'd1);
        cycle();
        check("fwd1_srcL", o_srcLeft, 32'hB);
        check("fwd_cnt", 32'(o_stallCount), 32'd0);
`else
        check("nofwd_ready", 32'(o_ready), 32'd0);
        cycle();
        check("nofwd_valid", 32'(o_valid), 32'd0);
        i_stageWe = 2'b00;
        #1;
        check("nofwd_ready2", 32'(o_ready), 32'd1);
        cycle();
        check("nofwd_srcL", o_srcLeft, 32'h55);
        check("nofwd_cnt", 32'(o_stallCount), 32'd1);
`endif

        // Load-use on r7: stage0 load result not yet available.
        i_addrLeft         = 5'd7;
        i_readValueLeft    = 32'h70;
        i_stageDest        = {5'd0, 5'd7};
        i_stageWe          = 2'b01;
        i_stageResultValid = 2'b00;
        i_stageResult      = {32'h0, 32'h77};
        #1;
        check("lu_ready", 32'(o_ready), 32'd0);
        cycle();
        check("lu_bubble", 32'(o_valid), 32'd0);
        // Load advances to stage1 with its data.
        i_stageDest        = {5'd7, 5'd0};
        i_stageWe          = 2'b10;
        i_stageResultValid = 2'b10;
        i_stageResult      = {32'h77, 32'h0};
        #1;
`ifdef ID_ISSUE_BYPASS_EN
        check("lu_ready2", 32'(o_ready), 32'd1);
        cycle();
        check("lu_srcL", o_srcLeft, 32'h77);
        check("lu_valid", 32'(o_valid), 32'd1);
        check("lu_cnt", 32'(o_stallCount), 32'd1);
`else
        check("lu_ready2", 32'(o_ready), 32'd0);
        cycle();
        i_stageWe = 2'b00;
        #1;
        check("lu_ready3", 32'(o_ready), 32'd1);
        cycle();
        check("lu_srcL", o_srcLeft, 32'h70);
        check("lu_valid", 32'(o_valid), 32'd1);
        check("lu_cnt", 32'(o_stallCount), 32'd3);
`endif

        // Back-pressure: A is held while EX refuses, then B follows once.
        i_stageWe  = 2'b00;
        i_leftSel  = 2'b10;
        i_imm      = 32'h1234;
        i_exop     = 8'h33;
        i_dest     = 5'd9;
        cycle();
        check("bp_a_srcL", o_srcLeft, 32'h1234);
        i_imm   = 32'h5678;
        i_exop  = 8'h44;
        i_ready = 1'b0;
        #1;
        check("bp_ready", 32'(o_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold_srcL", o_srcLeft, 32'h1234);
            check("bp_hold_exop", 32'(o_exop), 32'h33);
            check("bp_hold_valid", 32'(o_valid), 32'd1);
        end
        i_ready = 1'b1;
        #1;
        check("bp_ready2", 32'(o_ready), 32'd1);
        cycle();
        check("bp_b_srcL", o_srcLeft, 32'h5678);
        check("bp_b_exop", 32'(o_exop), 32'h44);
        i_valid = 1'b0;
        cycle();
        check("bp_no_dup", 32'(o_valid), 32'd0);

        // Flush with an incoming instruction: consumed and discarded.
        i_valid = 1'b1;
        i_imm   = 32'hAB;
        i_flush = 1'b1;
        #1;
        check("fl_ready", 32'(o_ready), 32'd1);
        cycle();
        check("fl_valid", 32'(o_valid), 32'd0);
        // Flush of a held instruction under back-pressure.
        i_flush = 1'b0;
        cycle();
        check("fl_load", 32'(o_valid), 32'd1);
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_flush = 1'b1;
        cycle();
        check("fl_hold", 32'(o_valid), 32'd0);
        i_flush = 1'b0;
        i_ready = 1'b1;

        // Register 0 never stalls and reads zero even with a busy writer.
        i_valid            = 1'b1;
        i_leftSel          = 2'b01;
        i_addrLeft         = 5'd0;
        i_readValueLeft    = 32'hDEAD;
        i_stageDest        = {5'd0, 5'd0};
        i_stageWe          = 2'b11;
        i_stageResultValid = 2'b00;
        #1;
        check("r0_ready", 32'(o_ready), 32'd1);
        cycle();
        check("r0_srcL", o_srcLeft, 32'h0);

        // Right-operand hazard held for 20 cycles saturates the counter.
        i_leftSel   = 2'b00;
        i_rightSel  = 2'b01;
        i_addrRight = 5'd7;
        i_stageDest = {5'd0, 5'd7};
        i_stageWe   = 2'b01;
        #1;
        check("sat_ready", 32'(o_ready), 32'd0);
        for (int i = 0; i < 20; i++) cycle();
        check("sat_cnt", 32'(o_stallCount), 32'd15);

        // Asynchronous reset mid-stall drops everything immediately.
        rst = 1'b1;
        #1;
        check("arst_cnt", 32'(o_stallCount), 32'd0);
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_ready", 32'(o_ready), 32'd0);
        idle_inputs();
        #1;
        rst = 1'b0;
        cycle();
        check("post_rst_valid", 32'(o_valid), 32'd0);
        check("post_rst_cnt", 32'(o_stallCount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_issue.md
# id_issue

Parametrised operand-fetch and issue stage sitting between instruction decode and EX. It resolves both source operands from the register file, an immediate, or any of `FWD_STAGES` downstream result buses. It stalls on unresolved RAW hazards such as load-use, and registers the issued instruction into an ID/EX output register with a valid/ready handshake and flush. It generalises the single-cycle forwarding decode to N forwarding stages, back-pressure and a stall counter.

## Interface
- `WORD_W`, 32, datapath width.
- `REG_ADDR_W`, 5, register address width.
- `EXOP_W`, 8, EX opcode width.
- `FWD_STAGES`, 2, number of forwarding sources; index 0 is youngest (EX), then MEM, and so on.
- `CNT_W`, 16, stall counter width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  decoded instruction present.
- `o_ready`  out  1  instruction accepted this cycle.
- `i_exop`  in  EXOP_W  EX operation.
- `i_leftSel`, `i_rightSel`  in  2  HSEL code: ZERO, REG or IMM.
- `i_addrLeft`, `i_addrRight`  in  REG_ADDR_W  source registers.
- `i_imm`, `i_offset`  in  WORD_W  immediate and offset.
- `i_dest`  in  REG_ADDR_W  destination register.
- `o_readAddrLeft`, `o_readAddrRight`  out  REG_ADDR_W  register file read addresses; combinational, equal to `i_addr*` when the select is REG, else 0.
- `i_readValueLeft`, `i_readValueRight`  in  WORD_W  register file data (write-before-read).
- `i_stageDest`  in  FWD_STAGES*REG_ADDR_W  per-stage destination, packed with stage 0 at the LSBs.
- `i_stageWe`  in  FWD_STAGES  stage will write its destination.
- `i_stageResultValid`  in  FWD_STAGES  stage result available now; 0 for a load still in flight.
- `i_stageResult`  in  FWD_STAGES*WORD_W  per-stage result.
- `i_flush`  in  1  squash the held and incoming instruction.
- `o_valid`  out  1  ID/EX register holds an instruction.
- `i_ready`  in  1  EX accepts.
- `o_exop`, `o_srcLeft`, `o_srcRight`, `o_offset`, `o_dest`  out  registered payload.
- `o_stallCount`  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- **Per-operand select.** Evaluated independently for each operand:
  - ZERO selects 0; IMM selects `i_imm`.
  - REG with address 0 selects 0 and never stalls.
  - Otherwise, the lowest stage index k with `i_stageWe[k]` set and a matching `i_stageDest[k]` is taken.
    - If `i_stageResultValid[k]` is set, select `i_stageResult[k]`.
    - Else raise hazard for that operand.
  - With no matching stage, select the register file value.
- `stall` = leftHazard OR rightHazard, gated by `i_valid`.
- `o_ready` = !stall AND (!o_valid OR i_ready) AND !rst.
- **Register update.** The output register updates when !o_valid OR i_ready:
  - on accept (`i_valid` AND `o_ready`), it loads the payload and sets `o_valid` = 1;
  - otherwise it loads a bubble: `o_valid` = 0, exop NOP, `o_dest` = 0.
- While o_valid AND !i_ready, the payload holds unchanged.
- **Flush.** `i_flush` clears `o_valid` on the next edge, and an instruction presented in the same cycle is consumed and discarded (`o_ready` is unchanged). Flush takes priority over accept and over hold.
- **Stall counter.** `o_stallCount` increments on every cycle with `i_valid` AND stall, saturates at all-ones, and does not wrap.

## Timing
- Latency from accept to `o_valid` is 1 cycle.
- `o_readAddr*` and `o_ready` are combinational.
- On reset, every output is 0, including `o_valid`, the payload and `o_stallCount`, and `o_exop` is NOP. This takes effect asynchronously.
- Reset asserted mid-stall drops the pending instruction; the upstream stage must re-present it.
- A load-use hazard costs exactly one stall cycle with the default configuration, because the producing load moves to stage 1 with a valid result.
- `i_ready` low with stall high: the held payload remains and the counter still increments.

## Configuration
- `ID_ISSUE_BYPASS_EN` defined: forwarding operates as described.
- Undefined: the forwarding paths are removed. Any REG operand, other than register 0, that matches any stage with `i_stageWe` set raises hazard regardless of `i_stageResultValid`, and operands always come from the register file.

## Structure
- Shared package `pipeline_pkg`:
  - HSEL codes ZERO=2'b00, REG=2'b01, IMM=2'b10;
  - the NOP exop encoding;
  - REG_ZERO;
  - default widths.
- One combinational sub-module `operand_select`, instantiated twice. It takes the select, address, immediate, register file value and stage buses, and outputs the value and the hazard flag.

## Test plan
- ORI-style: left REG r3, regfile 0x10, right IMM 0xFF, no stage matches -> 1 cycle later `o_valid`=1, srcLeft=0x10, srcRight=0xFF.
- Forward priority: r5 matches stage0 (result 0xA, valid) and stage1 (0xB) -> srcLeft=0xA; with stage0 We=0 -> 0xB.
- Load-use: r7 matches stage0, resultValid=0 for one cycle -> `o_ready`=0, one bubble issued, `o_stallCount`=1, then issue with the forwarded value.
- Back-pressure: `i_ready`=0 for 3 cycles -> payload stable, `o_ready`=0; resumes without loss or duplication.
- Flush with `i_valid`: both in the same cycle -> next `o_valid`=0, the instruction is never issued.
- Register 0 and counter saturation: r0 matching a busy stage -> no stall, value 0. With CNT_W=4, 20 stall cycles -> `o_stallCount`=15. Macro undefined, r5 matching stage1 valid -> stall.
